// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: flag bit positions and record layout.
package trace_pkg;

  localparam int unsigned FLG_VALID = 0;
  localparam int unsigned FLG_REGWR = 1;
  localparam int unsigned FLG_MEMRD = 2;
  localparam int unsigned FLG_MEMWR = 3;
  localparam int unsigned FLG_HALT  = 4;
  localparam int unsigned FLG_W     = 5;
  localparam int unsigned WREG_W    = 3;

  localparam int unsigned DW_DEF   = 16;
  localparam int unsigned CNTW_DEF = 32;
  localparam int unsigned REC_W    = 2 * CNTW_DEF + 5 * DW_DEF + WREG_W + FLG_W;

  // Record layout, MSB first: {inum, cycle, pc, inst, wdata, maddr, mdata, wreg, flags}
  function automatic int unsigned rec_width(input int unsigned cntw, input int unsigned dw);
    return 2 * cntw + 5 * dw + WREG_W + FLG_W;
  endfunction

endpackage

// File: rtl/trace_mwfifo.sv
// Multi-write / single-read FIFO: up to NWR entries written per cycle in slot order, one read.
module trace_mwfifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned NWR   = 2,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1,
  localparam int unsigned KW   = $clog2(NWR + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [KW-1:0]  i_wr_num,
  input  logic [NWR*W-1:0] i_wr_data,
  input  logic           i_rd_en,
  output logic [W-1:0]   o_rd_data,
  output logic [CW-1:0]  o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // Storage is not reset; the top masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NWR; j++) begin
      if (KW'(j) < i_wr_num) begin
        r_mem[r_wptr + AW'(j)] <= i_wr_data[j*W +: W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(i_wr_num);
      r_rptr  <= r_rptr + AW'(i_rd_en);
      r_count <= r_count + CW'(i_wr_num) - CW'(i_rd_en);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace capture: stamps up to NCH commits per cycle with INUM and cycle count, buffers
// them, and drains one record per cycle over valid/ready with halt and overflow tracking.
module commit_trace_buffer #(
  parameter int unsigned DW    = 16,
  parameter int unsigned NCH   = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    commit_valid,
  input  logic [NCH*DW-1:0] commit_pc,
  input  logic [NCH*DW-1:0] commit_inst,
  input  logic [NCH-1:0]    commit_regwr,
  input  logic [NCH*3-1:0]  commit_wreg,
  input  logic [NCH*DW-1:0] commit_wdata,
  input  logic [NCH-1:0]    commit_memrd,
  input  logic [NCH-1:0]    commit_memwr,
  input  logic [NCH*DW-1:0] commit_maddr,
  input  logic [NCH*DW-1:0] commit_mdata,
  input  logic [NCH-1:0]    commit_halt,
  output logic              commit_stall,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [CNTW-1:0]   rec_inum,
  output logic [CNTW-1:0]   rec_cycle,
  output logic [DW-1:0]     rec_pc,
  output logic [DW-1:0]     rec_inst,
  output logic [DW-1:0]     rec_wdata,
  output logic [DW-1:0]     rec_maddr,
  output logic [DW-1:0]     rec_mdata,
  output logic [2:0]        rec_wreg,
  output logic [4:0]        rec_flags,
  output logic              overflow,
  output logic              halted,
  output logic              trace_done
);
  import trace_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned KW = $clog2(NCH + 1);
  localparam int unsigned RW = rec_width(CNTW, DW);

  logic [CNTW-1:0]   r_cycle;
  logic [CNTW-1:0]   r_inum;
  logic              r_overflow;
  logic              r_halted;
  logic              r_done;

  logic [NCH-1:0]    w_elig;
  logic              w_kill;
  logic              w_halt_in;
  logic [KW-1:0]     w_k;
  logic [FLG_W-1:0]  w_flags;
  logic [RW-1:0]     w_rec;
  logic [NCH*RW-1:0] w_slot_data;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_free;
  logic [CW-1:0]     w_count_d;
  logic              w_fits;
  logic              w_drop;
  logic              w_pop;
  logic [KW-1:0]     w_push_num;
  logic              w_halted_d;
  logic [RW-1:0]     w_fifo_data;
  logic [RW-1:0]     w_head;

  // Eligibility masking and prefix-sum slot assignment; a halt kills all younger channels.
  always_comb begin
    w_elig      = '0;
    w_kill      = 1'b0;
    w_halt_in   = 1'b0;
    w_k         = '0;
    w_flags     = '0;
    w_rec       = '0;
    w_slot_data = '0;
    for (int i = 0; i < NCH; i++) begin
      w_elig[i] = commit_valid[i] & ~r_halted & ~w_kill;
      if (w_elig[i]) begin
        w_flags            = '0;
        w_flags[FLG_VALID] = 1'b1;
        w_flags[FLG_REGWR] = commit_regwr[i];
        w_flags[FLG_MEMRD] = commit_memrd[i];
        w_flags[FLG_MEMWR] = commit_memwr[i];
        w_flags[FLG_HALT]  = commit_halt[i];
        w_rec = {r_inum + CNTW'(w_k), r_cycle, commit_pc[i*DW +: DW], commit_inst[i*DW +: DW],
                 commit_wdata[i*DW +: DW], commit_maddr[i*DW +: DW], commit_mdata[i*DW +: DW],
                 commit_wreg[i*3 +: 3], w_flags};
        w_slot_data[w_k*RW +: RW] = w_rec;
        w_k = w_k + 1'b1;
        if (commit_halt[i]) begin
          w_kill    = 1'b1;
          w_halt_in = 1'b1;
        end
      end
    end
  end

  // Free space comes from the registered count only, so a same-cycle pop never admits a push.
  assign w_free     = CW'(DEPTH) - w_count;
  assign w_fits     = CW'(w_k) <= w_free;
  assign w_push_num = w_fits ? w_k : '0;
  assign w_drop     = (w_k != '0) & ~w_fits;
  assign rec_valid  = (w_count != '0);
  assign w_pop      = rec_valid & rec_ready;
  assign w_count_d  = w_count + CW'(w_push_num) - CW'(w_pop);
  assign w_halted_d = r_halted | (w_fits & w_halt_in);

  trace_mwfifo #(
    .W     (RW),
    .NWR   (NCH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_num  (w_push_num),
    .i_wr_data (w_slot_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_count   (w_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle    <= '0;
      r_inum     <= '0;
      r_overflow <= 1'b0;
      r_halted   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cycle    <= r_cycle + 1'b1;
      r_inum     <= r_inum + CNTW'(w_push_num);
      r_overflow <= r_overflow | w_drop;
      r_halted   <= w_halted_d;
      r_done     <= w_halted_d & (w_count_d == '0);
    end
  end

  assign commit_stall = (w_free < CW'(NCH)) | r_halted;
  assign overflow     = r_overflow;
  assign halted       = r_halted;
  assign trace_done   = r_done;

  assign w_head = rec_valid ? w_fifo_data : '0;
  assign {rec_inum, rec_cycle, rec_pc, rec_inst, rec_wdata, rec_maddr, rec_mdata, rec_wreg,
          rec_flags} = w_head;

endmodule
